// File: rtl/mux2_ch_scheduler_pkg.sv
// Shared types for the 2:1 channel mux scheduler.
package mux2_ch_scheduler_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StDwell  = 2'd2
   } state_e;

   localparam logic ModeManual = 1'b0;
   localparam logic ModeAuto   = 1'b1;

   function automatic logic is_busy(input state_e s);
      return s != StIdle;
   endfunction

endpackage

// File: rtl/mux2_ch_scheduler_sample_counter.sv
// Sample up-counter with clear; hit_o flags that the pending increment reaches limit_i.
module mux2_ch_scheduler_sample_counter #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 inc_i,
   input  logic [CNT_WIDTH-1:0] limit_i,
   output logic                 hit_o
);

   localparam logic [CNT_WIDTH-1:0] One  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0]   OneW = (CNT_WIDTH + 1)'(1);

   logic [CNT_WIDTH-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (inc_i) begin
         count_q <= count_q + One;
      end
   end

   // Extra bit keeps the +1 from wrapping; >= tolerates a limit that shrank under us.
   assign hit_o = ({1'b0, count_q} + OneW) >= {1'b0, limit_i};

endmodule

// File: rtl/mux2_ch_scheduler.sv
// Drives the 2:1 mux select, discards settling samples after each switch and
// forwards the remaining samples tagged with their channel.
module mux2_ch_scheduler
   import mux2_ch_scheduler_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 12,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned SETTLE_SAMPLES = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  MODE,
   input  logic                  MAN_SEL,
   input  logic [CNT_WIDTH-1:0]  DWELL1,
   input  logic [CNT_WIDTH-1:0]  DWELL2,
   input  logic                  DIN_VALID,
   input  logic [DATA_WIDTH-1:0] DIN,
   output logic                  SEL,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic                  DOUT_VALID,
   output logic                  DOUT_CH,
   output logic                  SWITCH_PULSE,
   output logic                  BUSY
);

   localparam logic [CNT_WIDTH-1:0] SettleLimit = CNT_WIDTH'(SETTLE_SAMPLES);
   localparam state_e PostSwitch = (SETTLE_SAMPLES == 0) ? StDwell : StSettle;

   state_e                state_q, state_d;
   logic                  sel_q, sel_d;
   logic                  mode_q, mode_d;
   logic [CNT_WIDTH-1:0]  lim_q, lim_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_ch_q, pulse_q, busy_q;
   logic                  fwd, pulse_d, new_slot;
   logic                  settle_clr, settle_inc, settle_hit;
   logic                  dwell_clr, dwell_inc, dwell_hit;
   logic [CNT_WIDTH-1:0]  dwell_sel;

   mux2_ch_scheduler_sample_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_settle_cnt (
      .clk_i   (CLK),
      .rst_i   (RST),
      .clr_i   (settle_clr),
      .inc_i   (settle_inc),
      .limit_i (SettleLimit),
      .hit_o   (settle_hit)
   );

   mux2_ch_scheduler_sample_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_dwell_cnt (
      .clk_i   (CLK),
      .rst_i   (RST),
      .clr_i   (dwell_clr),
      .inc_i   (dwell_inc),
      .limit_i (lim_q),
      .hit_o   (dwell_hit)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      mode_d     = mode_q;
      lim_d      = lim_q;
      dout_d     = dout_q;
      fwd        = 1'b0;
      pulse_d    = 1'b0;
      new_slot   = 1'b0;
      settle_clr = 1'b0;
      settle_inc = 1'b0;
      dwell_clr  = 1'b0;
      dwell_inc  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (EN) begin
               mode_d     = MODE;
               sel_d      = (MODE == ModeAuto) ? 1'b0 : MAN_SEL;
               pulse_d    = (sel_d != sel_q);
               new_slot   = 1'b1;
               settle_clr = 1'b1;
               dwell_clr  = 1'b1;
               state_d    = PostSwitch;
            end
         end
         StSettle: begin
            if (!EN) begin
               state_d = StIdle;
            end else if (mode_q == ModeManual && MAN_SEL != sel_q) begin
               sel_d      = MAN_SEL;
               pulse_d    = 1'b1;
               settle_clr = 1'b1;
            end else if (DIN_VALID) begin
               if (settle_hit) begin
                  settle_clr = 1'b1;
                  state_d    = StDwell;
               end else begin
                  settle_inc = 1'b1;
               end
            end
         end
         StDwell: begin
            if (!EN) begin
               state_d = StIdle;
            end else if (mode_q == ModeManual && MAN_SEL != sel_q) begin
               // Sample arriving on the switch cycle belongs to neither channel cleanly.
               sel_d      = MAN_SEL;
               pulse_d    = 1'b1;
               settle_clr = 1'b1;
               state_d    = PostSwitch;
            end else if (DIN_VALID) begin
               fwd    = 1'b1;
               dout_d = DIN;
               if (mode_q == ModeAuto) begin
                  if (dwell_hit) begin
                     sel_d      = ~sel_q;
                     pulse_d    = 1'b1;
                     new_slot   = 1'b1;
                     dwell_clr  = 1'b1;
                     settle_clr = 1'b1;
                     state_d    = PostSwitch;
                  end else begin
                     dwell_inc = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Dwell length is captured once per slot; a zero request still yields one sample.
      dwell_sel = sel_d ? DWELL2 : DWELL1;
      if (new_slot) begin
         lim_d = (dwell_sel == '0) ? CNT_WIDTH'(1) : dwell_sel;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StIdle;
         sel_q        <= 1'b0;
         mode_q       <= ModeManual;
         lim_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_ch_q    <= 1'b0;
         pulse_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         mode_q       <= mode_d;
         lim_q        <= lim_d;
         dout_q       <= dout_d;
         dout_valid_q <= fwd;
         if (fwd) begin
            dout_ch_q <= sel_q;
         end
         pulse_q      <= pulse_d;
         busy_q       <= is_busy(state_d);
      end
   end

   assign SEL          = sel_q;
   assign DOUT         = dout_q;
   assign DOUT_VALID   = dout_valid_q;
   assign DOUT_CH      = dout_ch_q;
   assign SWITCH_PULSE = pulse_q;
   assign BUSY         = busy_q;

endmodule

// File: tb/tb_mux2_ch_scheduler.sv
// Directed bench for mux2_ch_scheduler: per-cycle model comparison plus literal
// checks on the forwarded sample stream.
module tb_mux2_ch_scheduler;

   localparam int DW = 12;
   localparam int CW = 16;
   localparam int SS = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          EN = 1'b0;
   logic          MODE = 1'b0;
   logic          MAN_SEL = 1'b0;
   logic [CW-1:0] DWELL1 = 16'd3;
   logic [CW-1:0] DWELL2 = 16'd2;
   logic          DIN_VALID = 1'b0;
   logic [DW-1:0] DIN = '0;
   logic          SEL, DOUT_VALID, DOUT_CH, SWITCH_PULSE, BUSY;
   logic [DW-1:0] DOUT;

   mux2_ch_scheduler #(
      .DATA_WIDTH     (DW),
      .CNT_WIDTH      (CW),
      .SETTLE_SAMPLES (SS)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .EN           (EN),
      .MODE         (MODE),
      .MAN_SEL      (MAN_SEL),
      .DWELL1       (DWELL1),
      .DWELL2       (DWELL2),
      .DIN_VALID    (DIN_VALID),
      .DIN          (DIN),
      .SEL          (SEL),
      .DOUT         (DOUT),
      .DOUT_VALID   (DOUT_VALID),
      .DOUT_CH      (DOUT_CH),
      .SWITCH_PULSE (SWITCH_PULSE),
      .BUSY         (BUSY)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic          ch;
      logic [DW-1:0] d;
   } fwd_t;

   fwd_t fwd_q[$];
   int   pulse_cnt = 0;

   task automatic chk_fwd(input string name, input int idx, input logic ch, input int d);
      logic [31:0] exp;
      exp = {19'd0, ch, DW'(d)};
      if (idx < fwd_q.size()) chk(name, 32'(fwd_q[idx]), exp);
      else chk(name, 32'hFFFF_FFFF, exp);
   endtask

   // Model: phase 0 idle, 1 settling, 2 dwelling; counts are samples still to go.
   bit            m_sel, m_valid, m_ch, m_pulse, m_busy, m_auto, nsel;
   logic [DW-1:0] m_dout;
   int            m_phase, m_settle_left, m_dwell_left;

   function automatic int slot_len(input logic [CW-1:0] d);
      return (d == 0) ? 1 : int'(d);
   endfunction

   task automatic start_settle();
      if (SS == 0) m_phase = 2;
      else begin
         m_phase       = 1;
         m_settle_left = SS;
      end
   endtask

   always @(posedge CLK) begin
      m_valid = 1'b0;
      m_pulse = 1'b0;
      if (RST) begin
         m_sel = 0; m_ch = 0; m_auto = 0; m_dout = '0; m_phase = 0;
         m_settle_left = 0; m_dwell_left = 0;
      end else begin
         case (m_phase)
            0: if (EN) begin
               m_auto       = MODE;
               nsel         = MODE ? 1'b0 : MAN_SEL;
               m_pulse      = (nsel != m_sel);
               m_sel        = nsel;
               m_dwell_left = slot_len(m_sel ? DWELL2 : DWELL1);
               start_settle();
            end
            1: if (!EN) m_phase = 0;
               else if (!m_auto && MAN_SEL != m_sel) begin
                  m_sel = MAN_SEL; m_pulse = 1; start_settle();
               end else if (DIN_VALID) begin
                  m_settle_left--;
                  if (m_settle_left == 0) m_phase = 2;
               end
            default: if (!EN) m_phase = 0;
               else if (!m_auto && MAN_SEL != m_sel) begin
                  m_sel = MAN_SEL; m_pulse = 1; start_settle();
               end else if (DIN_VALID) begin
                  m_valid = 1; m_dout = DIN; m_ch = m_sel;
                  if (m_auto) begin
                     m_dwell_left--;
                     if (m_dwell_left == 0) begin
                        m_sel        = !m_sel;
                        m_pulse      = 1;
                        m_dwell_left = slot_len(m_sel ? DWELL2 : DWELL1);
                        start_settle();
                     end
                  end
               end
         endcase
      end
      m_busy = (m_phase != 0);
      #1;
      chk("sel", 32'(SEL), 32'(m_sel));
      chk("dout_valid", 32'(DOUT_VALID), 32'(m_valid));
      chk("dout", 32'(DOUT), 32'(m_dout));
      chk("dout_ch", 32'(DOUT_CH), 32'(m_ch));
      chk("switch_pulse", 32'(SWITCH_PULSE), 32'(m_pulse));
      chk("busy", 32'(BUSY), 32'(m_busy));
      if (DOUT_VALID === 1'b1) fwd_q.push_back({DOUT_CH, DOUT});
      if (SWITCH_PULSE === 1'b1) pulse_cnt++;
   end

   task automatic begin_run(input logic mode, input logic man);
      @(negedge CLK);
      MODE = mode; MAN_SEL = man; EN = 1'b1; DIN_VALID = 1'b0;
      fwd_q.delete();
      pulse_cnt = 0;
   endtask

   task automatic end_run();
      @(negedge CLK);
      EN = 1'b0; DIN_VALID = 1'b0;
      @(negedge CLK);
   endtask

   int k;

   initial begin
      // Reset with enable and strobes active
      RST = 1'b1; EN = 1'b1; DIN_VALID = 1'b1; DIN = 12'hABC;
      repeat (2) @(negedge CLK);
      chk("rst_sel", 32'(SEL), 0);
      chk("rst_dout", 32'(DOUT), 0);
      chk("rst_valid", 32'(DOUT_VALID), 0);
      chk("rst_ch", 32'(DOUT_CH), 0);
      chk("rst_pulse", 32'(SWITCH_PULSE), 0);
      chk("rst_busy", 32'(BUSY), 0);
      RST = 1'b0; EN = 1'b0; DIN_VALID = 1'b0;
      @(negedge CLK);

      // Auto, DWELL1=3 DWELL2=2, strobe every clock
      DWELL1 = 16'd3; DWELL2 = 16'd2;
      begin_run(1'b1, 1'b0);
      for (int i = 1; i <= 26; i++) begin
         @(negedge CLK);
         DIN_VALID = 1'b1; DIN = DW'(i);
      end
      end_run();
      chk("auto_count", 32'(fwd_q.size()), 10);
      chk_fwd("auto_f0", 0, 1'b0, 5);
      chk_fwd("auto_f2", 2, 1'b0, 7);
      chk_fwd("auto_f3", 3, 1'b1, 12);
      chk_fwd("auto_f4", 4, 1'b1, 13);
      chk_fwd("auto_f5", 5, 1'b0, 18);
      chk_fwd("auto_f9", 9, 1'b1, 26);
      chk("auto_pulses", 32'(pulse_cnt), 4);

      // Manual, MAN_SEL 0->1 mid-dwell
      begin_run(1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge CLK);
         DIN_VALID = 1'b1; DIN = DW'(i);
         if (i == 8) MAN_SEL = 1'b1;
      end
      end_run();
      chk("man_count", 32'(fwd_q.size()), 7);
      chk_fwd("man_f0", 0, 1'b0, 5);
      chk_fwd("man_f3", 3, 1'b1, 13);
      chk("man_pulses", 32'(pulse_cnt), 1);

      // Sparse strobes, DWELL1=0 behaves as 1
      DWELL1 = 16'd0; DWELL2 = 16'd1;
      begin_run(1'b1, 1'b1);
      k = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge CLK);
         DIN_VALID = (c % 3 == 0);
         if (c % 3 == 0) begin
            k++;
            DIN = DW'(k);
         end
      end
      end_run();
      chk("sparse_count", 32'(fwd_q.size()), 3);
      chk_fwd("sparse_f0", 0, 1'b0, 5);
      chk_fwd("sparse_f1", 1, 1'b1, 10);
      chk_fwd("sparse_f2", 2, 1'b0, 15);
      chk("sparse_pulses", 32'(pulse_cnt), 4);

      // EN drops on the cycle of the final dwell sample
      DWELL1 = 16'd3; DWELL2 = 16'd2;
      begin_run(1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         @(negedge CLK);
         DIN_VALID = 1'b1; DIN = DW'(i);
      end
      @(negedge CLK);
      EN = 1'b0; DIN = DW'(7);
      @(negedge CLK);
      chk("enlow_sel", 32'(SEL), 0);
      chk("enlow_valid", 32'(DOUT_VALID), 0);
      chk("enlow_busy", 32'(BUSY), 0);
      chk("enlow_dout", 32'(DOUT), 6);
      chk("enlow_count", 32'(fwd_q.size()), 2);
      DIN_VALID = 1'b0;
      @(negedge CLK);

      // Manual double toggle during settle
      begin_run(1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge CLK);
         DIN_VALID = 1'b1; DIN = DW'(i);
         if (i == 2) MAN_SEL = 1'b1;
         if (i == 3) MAN_SEL = 1'b0;
      end
      end_run();
      chk("tog_count", 32'(fwd_q.size()), 3);
      chk_fwd("tog_f0", 0, 1'b0, 8);
      chk("tog_pulses", 32'(pulse_cnt), 2);

      // Reset while dwelling
      begin_run(1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         @(negedge CLK);
         DIN_VALID = 1'b1; DIN = DW'(i + 40);
      end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("midrst_valid", 32'(DOUT_VALID), 0);
      chk("midrst_dout", 32'(DOUT), 0);
      chk("midrst_busy", 32'(BUSY), 0);
      RST = 1'b0; EN = 1'b0; DIN_VALID = 1'b0;
      repeat (2) @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
